// File: rtl/led_status_arbiter.sv
// ----------------------------------------------------------------------------
// led_status_arbiter : shares one status LED among four blink-code requesters
// Avalon-MM register slave, fixed-priority or round-robin arbitration.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_status_arbiter #(
   parameter logic [31:0] DEF_HALF = 32'd24_999_999,
   parameter logic [31:0] DEF_GAP  = 32'd49_999_999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  address,
   output logic [31:0] readdata,
   input  logic        read,
   input  logic [31:0] writedata,
   input  logic        write,
   input  logic [3:0]  req,
   output logic [3:0]  grant,
   output logic        busy,
   output logic        led
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [31:0] half_q, half_d;
   logic [31:0] gap_q, gap_d;
   logic [15:0] counts_q, counts_d;
   logic [31:0] tick_q, tick_d;
   logic [3:0]  grant_q, grant_d;
   logic [3:0]  rem_q, rem_d;
   logic [1:0]  idx_q, idx_d;
   logic [1:0]  last_q, last_d;
   logic        led_q, led_d;
   logic [31:0] readdata_q, readdata_d;

   logic [3:0]  eligible;
   logic [1:0]  search_base;
   logic [1:0]  cand;
   logic [1:0]  winner;
   logic        found;
   logic        abort;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         eligible[i] = req[i] & (counts_q[4*i +: 4] != 4'd0) & ctrl_q[0];
      end
   end

   // Round-robin starts one past the last completed grant; fixed priority from 0.
   always_comb begin
      winner      = 2'd0;
      found       = 1'b0;
      cand        = 2'd0;
      search_base = ctrl_q[1] ? (last_q + 2'd1) : 2'd0;
      for (int k = 0; k < 4; k++) begin
         cand = search_base + k[1:0];
         if (!found && eligible[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign abort = write && (address == 8'd0) && !writedata[0];

   always_comb begin
      ctrl_d   = ctrl_q;
      half_d   = half_q;
      gap_d    = gap_q;
      counts_d = counts_q;
      if (write) begin
         case (address)
            8'd0:    ctrl_d   = writedata[1:0];
            8'd1:    half_d   = writedata;
            8'd2:    gap_d    = writedata;
            8'd3:    counts_d = writedata[15:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      readdata_d = readdata_q;
      if (read && !write) begin
         case (address)
            8'd0:    readdata_d = {30'd0, ctrl_q};
            8'd1:    readdata_d = half_q;
            8'd2:    readdata_d = gap_q;
            8'd3:    readdata_d = {16'd0, counts_q};
            8'd4:    readdata_d = {20'd0, rem_q, 1'b0, state_q, (state_q != S_IDLE), grant_q};
            default: readdata_d = 32'd0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      grant_d = grant_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = 4'b0001 << winner;
               idx_d   = winner;
               rem_d   = counts_q[{winner, 2'b00} +: 4];
               tick_d  = 32'd0;
               state_d = S_ON;
            end
         end
         S_ON: begin
            if (tick_q >= half_q) begin
               tick_d  = 32'd0;
               rem_d   = rem_q - 4'd1;
               state_d = S_OFF;
            end else begin
               tick_d = tick_q + 32'd1;
            end
         end
         S_OFF: begin
            if (tick_q >= half_q) begin
               tick_d  = 32'd0;
               state_d = (rem_q != 4'd0) ? S_ON : S_GAP;
            end else begin
               tick_d = tick_q + 32'd1;
            end
         end
         S_GAP: begin
            if (tick_q >= gap_q) begin
               tick_d  = 32'd0;
               grant_d = 4'd0;
               last_d  = idx_q;
               state_d = S_IDLE;
            end else begin
               tick_d = tick_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Disabling aborts at once and leaves the round-robin pointer untouched.
      if (abort) begin
         state_d = S_IDLE;
         tick_d  = 32'd0;
         grant_d = 4'd0;
         rem_d   = 4'd0;
         last_d  = last_q;
      end
      led_d = (state_d == S_ON);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ctrl_q     <= 2'd0;
         half_q     <= DEF_HALF;
         gap_q      <= DEF_GAP;
         counts_q   <= 16'd0;
         tick_q     <= 32'd0;
         grant_q    <= 4'd0;
         rem_q      <= 4'd0;
         idx_q      <= 2'd0;
         last_q     <= 2'd3;
         led_q      <= 1'b0;
         readdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         half_q     <= half_d;
         gap_q      <= gap_d;
         counts_q   <= counts_d;
         tick_q     <= tick_d;
         grant_q    <= grant_d;
         rem_q      <= rem_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         led_q      <= led_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign grant    = grant_q;
   assign busy     = (state_q != S_IDLE);
   assign led      = led_q;

endmodule

`default_nettype wire

// File: doc/led_status_arbiter.md
# led_status_arbiter

Shares the board's single status LED among four status sources. Each source requests a blink code of a programmable number of pulses. The block arbitrates between the requesters and sequences the LED through on, off and gap phases. It is an Avalon-MM slave on the same register bus as the other LED control logic, and it drives the LED pin directly.

## Interface
Parameters:
- DEF_HALF, 32'd24_999_999: reset value of HALF register
- DEF_GAP, 32'd49_999_999: reset value of GAP register

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state and registers
- address  in  8  Avalon word address
- readdata  out  32  read data, registered
- read  in  1  read strobe
- writedata  in  32  write data
- write  in  1  write strobe
- req  in  4  level-sensitive blink requests; bit i = requester i
- grant  out  4  one-hot; the requester currently being played; 0 when idle
- busy  out  1  high while a sequence is in progress (state != IDLE)
- led  out  1  LED drive, active-high

## Operation
Register map (word address):
- 0 CTRL (rw): bit0 EN, bit1 RR (0 = fixed priority with lowest index first, 1 = round-robin). Other bits read as 0. Reset value 0.
- 1 HALF (rw, 32b): on-time and off-time are each HALF+1 cycles. Reset value DEF_HALF.
- 2 GAP (rw, 32b): gap after the last pulse is GAP+1 cycles. Reset value DEF_GAP.
- 3 COUNTS (rw): nibble i (bits 4i+3:4i) = pulse count for requester i. A value of 0 masks that requester. Bits 31:16 read as 0. Reset value 0.
- 4 STATUS (ro): [3:0] grant, [4] busy, [6:5] state (IDLE=0, ON=1, OFF=2, GAP=3), [11:8] pulses remaining, other bits 0.
- Any other address: reads return 0 and writes are ignored.
- If write and read are asserted together, the write executes and readdata holds its previous value.

Arbitration:
- Arbitration happens only in IDLE. The eligible set is req[i] & (COUNTS nibble i != 0) & EN.
- Fixed priority: the lowest eligible index wins.
- RR: the search starts at (last granted index + 1) mod 4. Last granted resets to 3, so the first search starts at index 0.

FSM:
- IDLE: leaves when the eligible set is non-empty. Latch the winner's index into grant and its count into the remaining counter, clear the tick counter, then go to ON.
- ON: led=1. When tick >= HALF, clear tick, decrement remaining, go to OFF.
- OFF: led=0. When tick >= HALF: go to ON if remaining != 0, otherwise go to GAP. Clear tick in both cases.
- GAP: led=0. When tick >= GAP, clear tick, clear grant, go to IDLE.
- The tick counter is 32 bits and increments every cycle in ON, OFF and GAP.
- Terminal compare is >=, against the live register. If HALF or GAP is written lower than the current tick, the phase ends on the next cycle.
- The count is latched at grant. Rewriting COUNTS mid-sequence does not change the current sequence.
- Deasserting req mid-sequence does not abort; the sequence completes.
- Clearing EN mid-sequence aborts: on the cycle after the write, state=IDLE, led=0, grant=0, tick=0. RR last-granted is not updated on an abort.

## Timing
- After reset: led=0, grant=0, busy=0, readdata=0, state=IDLE, tick=0.
- Read latency is 1 cycle: readdata is valid on the cycle after read is sampled, and holds until the next read.
- Written values take effect on the cycle after write is sampled.
- Grant latency: an eligible req sampled in IDLE at edge k gives grant, busy and led=1 after edge k.
- A sequence of N pulses occupies 2N(HALF+1)+(GAP+1) cycles, then spends at least 1 cycle in IDLE before the next grant.
- led, grant and busy are driven from registers, so they are glitch-free.

## Test plan
- Reset check: assert reset mid-ON. Required: led, grant, busy go to 0 asynchronously; reading registers 0-3 returns 0, DEF_HALF, DEF_GAP, 0.
- Single requester: HALF=2, GAP=4, COUNTS=0x0002, EN=1, pulse req[0] for 1 cycle. Required: led high 3 cycles, low 3, high 3, low 3, then 5 gap cycles with led=0; grant=0001 for the whole 17 cycles, then 0.
- Fixed priority: COUNTS=0x1111, RR=0, req=4'b1111 held. Required: grant is always 0001.
- Round-robin: same setup with RR=1. Required: grants go 0001, 0010, 0100, 1000, 0001.
- Masking and disable: COUNTS=0x0010, req=4'b0001. Required: never granted. Then set COUNTS=0x0011, EN=1, and write EN=0 during OFF. Required: IDLE, led=0, grant=0 on the next cycle.
- Live limit change: HALF=100, write HALF=5 while tick is 50 in ON. Required: transition to OFF on the next cycle; the OFF phase then lasts 6 cycles.
